// File: rtl/audio_pkg.sv
// audio_pkg: shared types for the codec audio path (sample width, stereo pair,
// transmit serialiser states).
package audio_pkg;

   localparam int DEFAULT_DATA_W = 24;

   typedef struct packed {
      logic [DEFAULT_DATA_W-1:0] left;
      logic [DEFAULT_DATA_W-1:0] right;
   } stereo_pair_t;

   typedef enum logic [1:0] {
      IDLE,
      LEFT,
      RIGHT
   } tx_state_t;

endpackage

// File: rtl/sample_fifo.sv
// sample_fifo: synchronous FIFO of stereo pairs; push is ignored when full and
// pop is ignored when empty, so callers may strobe either unconditionally.
module sample_fifo
   import audio_pkg::*;
#(
   parameter type pair_t = stereo_pair_t,
   parameter int  DEPTH  = 4,
   parameter int  LVL_W  = $clog2(DEPTH) + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  pair_t            push_data,
   input  logic             pop,
   output pair_t            head,
   output logic             full,
   output logic             empty,
   output logic [LVL_W-1:0] level
);

   localparam int PTR_W = $clog2(DEPTH);

   pair_t              mem [DEPTH];
   logic [PTR_W-1:0]   wr_ptr;
   logic [PTR_W-1:0]   rd_ptr;
   logic               accept;
   logic               take;

   assign full   = (level == LVL_W'(DEPTH));
   assign empty  = (level == '0);
   assign accept = push & ~full;
   assign take   = pop & ~empty;
   assign head   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (accept) begin
         mem[wr_ptr] <= push_data;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (accept) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (take) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({accept, take})
            2'b10:   level <= level + LVL_W'(1);
            2'b01:   level <= level - LVL_W'(1);
            default: level <= level;
         endcase
      end
   end

endmodule

// File: rtl/i2s_dac_tx.sv
// i2s_dac_tx: FIFO-buffered I2S transmitter slaved to codec AUD_BCLK/AUD_DACLRCK.
// Define I2S_DAC_UNDERRUN_CNT_EN to add the saturating underrun_count output.
module i2s_dac_tx
   import audio_pkg::*;
#(
   parameter int DATA_W      = DEFAULT_DATA_W,
   parameter int FIFO_DEPTH  = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          write,
   input  logic [DATA_W-1:0]             writedata_left,
   input  logic [DATA_W-1:0]             writedata_right,
   output logic                          write_ready,
   input  logic                          AUD_BCLK,
   input  logic                          AUD_DACLRCK,
   output logic                          AUD_DACDAT,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          underrun
`ifdef I2S_DAC_UNDERRUN_CNT_EN
   ,
   output logic [15:0]                   underrun_count
`endif
);

   localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
   localparam int IDX_W = $clog2(DATA_W);
   localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(DATA_W - 1);

   typedef struct packed {
      logic [DATA_W-1:0] left;
      logic [DATA_W-1:0] right;
   } pair_t;

   logic [SYNC_STAGES-1:0]   bclk_sync;
   logic [SYNC_STAGES-1:0]   lrck_sync;
   logic                     bclk_s;
   logic                     lrck_s;
   logic                     bclk_dly;
   logic                     lrck_q;
   logic                     bclk_rise;
   logic                     bclk_fall;
   logic                     frame_start;
   logic                     right_start;

   pair_t                    push_pair;
   pair_t                    fifo_head;
   logic                     fifo_full;
   logic                     fifo_empty;

   tx_state_t                state;
   logic [IDX_W-1:0]         bit_idx;
   logic                     bits_done;
   logic signed [DATA_W-1:0] left_word;
   logic signed [DATA_W-1:0] right_word;
   logic signed [DATA_W-1:0] cur_word;

   // Synchroniser chains run free so a reset never fabricates a BCLK edge.
   always_ff @(posedge clk) begin
      bclk_sync[0] <= AUD_BCLK;
      lrck_sync[0] <= AUD_DACLRCK;
      for (int i = 1; i < SYNC_STAGES; i++) begin
         bclk_sync[i] <= bclk_sync[i-1];
         lrck_sync[i] <= lrck_sync[i-1];
      end
      bclk_dly <= bclk_s;
   end

   assign bclk_s      = bclk_sync[SYNC_STAGES-1];
   assign lrck_s      = lrck_sync[SYNC_STAGES-1];
   assign bclk_rise   = bclk_s & ~bclk_dly;
   assign bclk_fall   = ~bclk_s & bclk_dly;
   assign frame_start = bclk_rise & lrck_q & ~lrck_s;
   assign right_start = bclk_rise & ~lrck_q & lrck_s;

   assign push_pair   = '{left: writedata_left, right: writedata_right};
   assign write_ready = ~fifo_full;

   sample_fifo #(
      .pair_t (pair_t),
      .DEPTH  (FIFO_DEPTH),
      .LVL_W  (LVL_W)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (write),
      .push_data (push_pair),
      .pop       (frame_start),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   // An empty FIFO at the left boundary sends silence for the whole frame.
   always_ff @(posedge clk) begin
      if (frame_start) begin
         left_word  <= fifo_empty ? '0 : fifo_head.left;
         right_word <= fifo_empty ? '0 : fifo_head.right;
      end
   end

   assign cur_word = (state == RIGHT) ? right_word : left_word;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state      <= IDLE;
         AUD_DACDAT <= 1'b0;
         underrun   <= 1'b0;
         lrck_q     <= 1'b0;
         bit_idx    <= IDX_MSB;
         bits_done  <= 1'b1;
      end else begin
         underrun <= 1'b0;
         if (bclk_rise) begin
            lrck_q <= lrck_s;
         end
         if (frame_start) begin
            state     <= LEFT;
            underrun  <= fifo_empty;
            bit_idx   <= IDX_MSB;
            bits_done <= 1'b0;
         end else if (right_start && state == LEFT) begin
            state     <= RIGHT;
            bit_idx   <= IDX_MSB;
            bits_done <= 1'b0;
         end else if (bclk_fall && state != IDLE) begin
            // Slots beyond DATA_W carry zeros until the next LRCK edge.
            if (!bits_done) begin
               AUD_DACDAT <= cur_word[bit_idx];
               if (bit_idx == '0) begin
                  bits_done <= 1'b1;
               end else begin
                  bit_idx <= bit_idx - IDX_W'(1);
               end
            end else begin
               AUD_DACDAT <= 1'b0;
            end
         end
      end
   end

`ifdef I2S_DAC_UNDERRUN_CNT_EN
   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   always_ff @(posedge clk) begin
      if (!reset) begin
         underrun_count <= '0;
      end else if (underrun) begin
         underrun_count <= sat_inc16(underrun_count);
      end
   end
`endif

endmodule

// File: tb/tb_i2s_dac_tx.sv
// tb_i2s_dac_tx: drives a codec-style BCLK/LRCK, deserialises AUD_DACDAT on BCLK
// rise with a one-bit delay and compares against a queue model of the FIFO.
module tb_i2s_dac_tx;

   localparam int DATA_W      = 24;
   localparam int FIFO_DEPTH  = 4;
   localparam int SYNC_STAGES = 2;
   localparam int LVL_W       = $clog2(FIFO_DEPTH) + 1;

   logic              clk;
   logic              reset;
   logic              write;
   logic [DATA_W-1:0] writedata_left;
   logic [DATA_W-1:0] writedata_right;
   logic              write_ready;
   logic              AUD_BCLK;
   logic              AUD_DACLRCK;
   logic              AUD_DACDAT;
   logic [LVL_W-1:0]  fifo_level;
   logic              underrun;
`ifdef I2S_DAC_UNDERRUN_CNT_EN
   logic [15:0]       underrun_count;
`endif

   i2s_dac_tx #(
      .DATA_W      (DATA_W),
      .FIFO_DEPTH  (FIFO_DEPTH),
      .SYNC_STAGES (SYNC_STAGES)
   ) dut (
      .clk             (clk),
      .reset           (reset),
      .write           (write),
      .writedata_left  (writedata_left),
      .writedata_right (writedata_right),
      .write_ready     (write_ready),
      .AUD_BCLK        (AUD_BCLK),
      .AUD_DACLRCK     (AUD_DACLRCK),
      .AUD_DACDAT      (AUD_DACDAT),
      .fifo_level      (fifo_level),
      .underrun        (underrun)
`ifdef I2S_DAC_UNDERRUN_CNT_EN
      ,
      .underrun_count  (underrun_count)
`endif
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference model: queue of {left,right} pairs and expected underrun count.
   logic [2*DATA_W-1:0] model_q[$];
   int                  exp_underruns = 0;

   int   ur_pulses = 0;
   int   ur_high   = 0;
   logic ur_prev   = 1'b0;

   always @(negedge clk) begin
      ur_prev <= underrun;
      if (underrun === 1'b1) ur_high <= ur_high + 1;
      if (underrun === 1'b1 && ur_prev !== 1'b1) ur_pulses <= ur_pulses + 1;
   end

   int                g_half    = 8;
   int                g_slots   = 32;
   bit                g_push_en = 1'b0;
   logic [DATA_W-1:0] g_pl      = '0;
   logic [DATA_W-1:0] g_pr      = '0;
   int                g_abort   = -1;

   task automatic step_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Expected capture of nbits slots: MSB-first sample bits up to index cut, zeros elsewhere.
   function automatic logic [63:0] exp_cap(input logic [DATA_W-1:0] s, input int nbits, input int cut);
      logic [63:0] w = '0;
      logic        b;
      for (int k = 0; k < nbits; k++) begin
         b = 1'b0;
         if (k < DATA_W && k <= cut) b = s[DATA_W-1-k];
         w = {w[62:0], b};
      end
      return w;
   endfunction

   task automatic push_pair(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
      check("write_ready", {63'd0, write_ready}, {63'd0, model_q.size() < FIFO_DEPTH});
      writedata_left  = l;
      writedata_right = r;
      write           = 1'b1;
      step_clk(1);
      write           = 1'b0;
      if (model_q.size() < FIFO_DEPTH) model_q.push_back({l, r});
   endtask

   task automatic lead_in();
      AUD_BCLK    = 1'b0;
      AUD_DACLRCK = 1'b1;
      step_clk(g_half);
      AUD_BCLK    = 1'b1;
      step_clk(g_half);
   endtask

   task automatic run_frame(input string tag);
      logic [DATA_W-1:0] fr_l;
      logic [DATA_W-1:0] fr_r;
      logic [63:0]       cap [2];
      logic              level_ok;
      int                cut;
      cut      = DATA_W;
      level_ok = 1'b1;
      cap[0]   = '0;
      cap[1]   = '0;
      if (model_q.size() == 0) begin
         fr_l = '0;
         fr_r = '0;
         exp_underruns++;
      end else begin
         {fr_l, fr_r} = model_q.pop_front();
      end
      if (g_push_en && model_q.size() < FIFO_DEPTH) model_q.push_back({g_pl, g_pr});
      for (int ch = 0; ch < 2; ch++) begin
         for (int p = 0; p < g_slots; p++) begin
            AUD_BCLK = 1'b0;
            if (p == 0) AUD_DACLRCK = (ch == 1);
            step_clk(g_half);
            if (p > 0) cap[ch] = {cap[ch][62:0], AUD_DACDAT};
            AUD_BCLK = 1'b1;
            for (int c = 0; c < g_half; c++) begin
               step_clk(1);
               if (ch == 0 && p == 0 && g_push_en) begin
                  if (c == 1) begin
                     writedata_left  = g_pl;
                     writedata_right = g_pr;
                     write           = 1'b1;
                  end
                  if (c == 2) write = 1'b0;
                  if (c < 6 && fifo_level !== LVL_W'(1)) level_ok = 1'b0;
               end
               if (ch == 0 && p == g_abort) begin
                  if (c == 1) reset = 1'b0;
                  if (c == 2) begin
                     reset = 1'b1;
                     check({tag, "_rst_dacdat"}, {63'd0, AUD_DACDAT}, 64'd0);
                     check({tag, "_rst_level"}, {{(64-LVL_W){1'b0}}, fifo_level}, 64'd0);
                     check({tag, "_rst_ready"}, {63'd0, write_ready}, 64'd1);
                     model_q.delete();
                     cut  = p - 1;
                     fr_r = '0;
                  end
               end
            end
         end
      end
      if (g_push_en) check({tag, "_level_hold"}, {63'd0, level_ok}, 64'd1);
      check({tag, "_left"}, cap[0], exp_cap(fr_l, g_slots - 1, cut));
      check({tag, "_right"}, cap[1], exp_cap(fr_r, g_slots - 1, DATA_W));
   endtask

   int base_pulses;
   int base_high;

   initial begin
      reset           = 1'b0;
      write           = 1'b0;
      writedata_left  = '0;
      writedata_right = '0;
      AUD_BCLK        = 1'b0;
      AUD_DACLRCK     = 1'b1;
      step_clk(4);
      check("rst_ready", {63'd0, write_ready}, 64'd1);
      check("rst_level", {{(64-LVL_W){1'b0}}, fifo_level}, 64'd0);
      check("rst_dacdat", {63'd0, AUD_DACDAT}, 64'd0);
      check("rst_underrun", {63'd0, underrun}, 64'd0);
      reset = 1'b1;
      step_clk(2);

      // Known pattern, slow BCLK, 32 slots per channel.
      g_half  = 32;
      g_slots = 32;
      lead_in();
      push_pair(24'hA5A5A5, 24'h3C3C3C);
      step_clk(1);
      check("t1_level_pre", {{(64-LVL_W){1'b0}}, fifo_level}, 64'd1);
      run_frame("t1");
      check("t1_level_post", {{(64-LVL_W){1'b0}}, fifo_level}, 64'd0);

      // Overfill with no frames running, then drain in order.
      g_half = 8;
      for (int i = 0; i < 5; i++) push_pair(DATA_W'($urandom), DATA_W'($urandom));
      step_clk(1);
      check("t2_ready_full", {63'd0, write_ready}, 64'd0);
      check("t2_level_full", {{(64-LVL_W){1'b0}}, fifo_level}, 64'd4);
      for (int i = 0; i < 4; i++) run_frame("t2");
      check("t2_level_drained", {{(64-LVL_W){1'b0}}, fifo_level}, 64'd0);

      // Empty FIFO: silent frames, one underrun pulse per frame.
      reset = 1'b0;
      step_clk(2);
      reset = 1'b1;
      step_clk(1);
      model_q.delete();
      base_pulses = ur_pulses;
      base_high   = ur_high;
      lead_in();
      for (int i = 0; i < 3; i++) run_frame("t3");
      step_clk(2);
      check("t3_pulses", 64'(ur_pulses - base_pulses), 64'd3);
      check("t3_pulse_width", 64'(ur_high - base_high), 64'd3);
`ifdef I2S_DAC_UNDERRUN_CNT_EN
      check("t3_underrun_count", {48'd0, underrun_count}, 64'd3);
`endif

      // Push on the exact pop cycle with one pair stored.
      push_pair(DATA_W'($urandom), DATA_W'($urandom));
      g_push_en = 1'b1;
      g_pl      = DATA_W'($urandom);
      g_pr      = DATA_W'($urandom);
      run_frame("t4a");
      g_push_en = 1'b0;
      check("t4_level_after", {{(64-LVL_W){1'b0}}, fifo_level}, 64'd1);
      run_frame("t4b");
      check("t4_level_end", {{(64-LVL_W){1'b0}}, fifo_level}, 64'd0);

      // Reset mid-LEFT after bit 10, then recovery on the next left boundary.
      push_pair(DATA_W'($urandom), DATA_W'($urandom));
      g_abort = 11;
      run_frame("t5a");
      g_abort = -1;
      push_pair(DATA_W'($urandom), DATA_W'($urandom));
      run_frame("t5b");

      // Short frames: 16 slots per channel truncate each sample.
      g_slots = 16;
      for (int i = 0; i < 3; i++) push_pair(DATA_W'($urandom), DATA_W'($urandom));
      for (int i = 0; i < 4; i++) run_frame("t6");
      step_clk(2);
      check("all_underrun_pulses", 64'(ur_pulses), 64'(exp_underruns));
      check("all_underrun_width", 64'(ur_high), 64'(exp_underruns));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
